// File: rtl/qspi_bus_arbiter.sv
// qspi_bus_arbiter: shares one QSPI controller between the fetch and data ports.
// Round-robin on conflict, per-transaction timeout, enforced CS-high gap.
module qspi_bus_arbiter #(
    parameter int ADDR_W  = 24,
    parameter int CS_GAP  = 2,
    parameter int TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_done,
    output logic              f_err,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_we,
    input  logic              d_sel,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_done,
    output logic              d_err,
    output logic [31:0]       rdata,
    input  logic              m_ready,
    output logic              m_start,
    output logic [ADDR_W-1:0] m_addr,
    output logic              m_we,
    output logic [31:0]       m_wdata,
    output logic [1:0]        m_cs_sel,
    input  logic              m_done,
    input  logic [31:0]       m_rdata,
    output logic              m_abort
);

    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int GW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
    // Abort decision is taken in the TIMEOUT-th BUSY cycle so the pulse
    // lands TIMEOUT+1 cycles after m_start.
    localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [GW-1:0] G_LAST = GW'((CS_GAP > 0) ? CS_GAP - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_BUSY,
        S_GAP
    } state_t;

    state_t state_q, state_d;

    logic [TW-1:0]     timer_q;
    logic [GW-1:0]     gap_q;
    logic              last_d_q;
    logic              own_d_q;
    logic              f_gnt_q, d_gnt_q;
    logic              f_done_q, f_err_q;
    logic              d_done_q, d_err_q;
    logic              m_abort_q;
    logic [31:0]       rdata_q;
    logic [ADDR_W-1:0] m_addr_q;
    logic              m_we_q;
    logic [31:0]       m_wdata_q;
    logic [1:0]        sel_q;

    logic pick_f, pick_d, bad_wr, fin_ok, fin_to;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus the arbitration and completion events it implies.
    always_comb begin
        state_d = state_q;
        pick_f  = 1'b0;
        pick_d  = 1'b0;
        bad_wr  = 1'b0;
        fin_ok  = 1'b0;
        fin_to  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (m_ready && (f_req || d_req)) begin
                    if (f_req && (!d_req || last_d_q)) begin
                        pick_f = 1'b1;
                    end else begin
                        pick_d = 1'b1;
                    end
                    bad_wr = pick_d && d_we && !d_sel;
                    if (!bad_wr) begin
                        state_d = S_ISSUE;
                    end else if (CS_GAP == 0) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_GAP;
                    end
                end
            end
            S_ISSUE: begin
                state_d = S_BUSY;
            end
            S_BUSY: begin
                if (m_done) begin
                    fin_ok = 1'b1;
                end else if (timer_q == T_LAST) begin
                    fin_to = 1'b1;
                end
                if (fin_ok || fin_to) begin
                    if (CS_GAP == 0) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (gap_q == G_LAST) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Grant latching, completion pulses, timers and read-data capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q   <= '0;
            gap_q     <= '0;
            last_d_q  <= 1'b1;
            own_d_q   <= 1'b0;
            f_gnt_q   <= 1'b0;
            d_gnt_q   <= 1'b0;
            f_done_q  <= 1'b0;
            f_err_q   <= 1'b0;
            d_done_q  <= 1'b0;
            d_err_q   <= 1'b0;
            m_abort_q <= 1'b0;
            rdata_q   <= '0;
            m_addr_q  <= '0;
            m_we_q    <= 1'b0;
            m_wdata_q <= '0;
            sel_q     <= 2'b00;
        end else begin
            f_done_q  <= fin_ok && !own_d_q;
            f_err_q   <= fin_to && !own_d_q;
            d_done_q  <= fin_ok && own_d_q;
            d_err_q   <= bad_wr || (fin_to && own_d_q);
            m_abort_q <= fin_to;
            if (pick_f || pick_d) begin
                last_d_q <= pick_d;
            end
            if (pick_f || (pick_d && !bad_wr)) begin
                own_d_q   <= pick_d;
                f_gnt_q   <= pick_f;
                d_gnt_q   <= pick_d;
                m_addr_q  <= pick_d ? d_addr : f_addr;
                m_we_q    <= pick_d && d_we;
                m_wdata_q <= pick_d ? d_wdata : 32'd0;
                sel_q     <= (pick_d && d_sel) ? 2'b10 : 2'b01;
            end
            if (fin_ok || fin_to) begin
                f_gnt_q <= 1'b0;
                d_gnt_q <= 1'b0;
            end
            if (fin_ok) begin
                rdata_q <= m_rdata;
            end
            if (state_q == S_ISSUE) begin
                timer_q <= '0;
            end else if (state_q == S_BUSY) begin
                timer_q <= timer_q + 1'b1;
            end
            if (state_q == S_GAP) begin
                gap_q <= gap_q + 1'b1;
            end else begin
                gap_q <= '0;
            end
        end
    end

    // Controller-facing strobes decoded from the current state.
    always_comb begin
        m_start  = (state_q == S_ISSUE);
        m_cs_sel = 2'b00;
        if (state_q == S_ISSUE || state_q == S_BUSY) begin
            m_cs_sel = sel_q;
        end
    end

    assign f_gnt   = f_gnt_q;
    assign d_gnt   = d_gnt_q;
    assign f_done  = f_done_q;
    assign f_err   = f_err_q;
    assign d_done  = d_done_q;
    assign d_err   = d_err_q;
    assign m_abort = m_abort_q;
    assign rdata   = rdata_q;
    assign m_addr  = m_addr_q;
    assign m_we    = m_we_q;
    assign m_wdata = m_wdata_q;

endmodule

// File: tb/tb_qspi_bus_arbiter.sv
// tb_qspi_bus_arbiter: directed checks of arbitration, timeout, gap and reset.
// A second instance built with CS_GAP=0 covers back-to-back issue.
module tb_qspi_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        f_req;
    logic [23:0] f_addr;
    logic        f_gnt, f_done, f_err;
    logic        d_req;
    logic [23:0] d_addr;
    logic        d_we, d_sel;
    logic [31:0] d_wdata;
    logic        d_gnt, d_done, d_err;
    logic [31:0] rdata;
    logic        m_ready, m_start;
    logic [23:0] m_addr;
    logic        m_we;
    logic [31:0] m_wdata;
    logic [1:0]  m_cs_sel;
    logic        m_done;
    logic [31:0] m_rdata;
    logic        m_abort;

    logic        b_rst;
    logic        b_f_req;
    logic [23:0] b_f_addr;
    logic        b_f_gnt, b_f_done, b_f_err;
    logic        b_d_req;
    logic [23:0] b_d_addr;
    logic        b_d_we, b_d_sel;
    logic [31:0] b_d_wdata;
    logic        b_d_gnt, b_d_done, b_d_err;
    logic [31:0] b_rdata;
    logic        b_m_ready, b_m_start;
    logic [23:0] b_m_addr;
    logic        b_m_we;
    logic [31:0] b_m_wdata;
    logic [1:0]  b_m_cs_sel;
    logic        b_m_done;
    logic [31:0] b_m_rdata;
    logic        b_m_abort;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    qspi_bus_arbiter #(.ADDR_W(24), .CS_GAP(2), .TIMEOUT(1023)) dut (
        .clk(clk), .rst(rst),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt),
        .f_done(f_done), .f_err(f_err),
        .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_sel(d_sel),
        .d_wdata(d_wdata), .d_gnt(d_gnt), .d_done(d_done), .d_err(d_err),
        .rdata(rdata), .m_ready(m_ready), .m_start(m_start),
        .m_addr(m_addr), .m_we(m_we), .m_wdata(m_wdata),
        .m_cs_sel(m_cs_sel), .m_done(m_done), .m_rdata(m_rdata),
        .m_abort(m_abort)
    );

    qspi_bus_arbiter #(.ADDR_W(24), .CS_GAP(0), .TIMEOUT(1023)) dut_b (
        .clk(clk), .rst(b_rst),
        .f_req(b_f_req), .f_addr(b_f_addr), .f_gnt(b_f_gnt),
        .f_done(b_f_done), .f_err(b_f_err),
        .d_req(b_d_req), .d_addr(b_d_addr), .d_we(b_d_we),
        .d_sel(b_d_sel), .d_wdata(b_d_wdata), .d_gnt(b_d_gnt),
        .d_done(b_d_done), .d_err(b_d_err), .rdata(b_rdata),
        .m_ready(b_m_ready), .m_start(b_m_start), .m_addr(b_m_addr),
        .m_we(b_m_we), .m_wdata(b_m_wdata), .m_cs_sel(b_m_cs_sel),
        .m_done(b_m_done), .m_rdata(b_m_rdata), .m_abort(b_m_abort)
    );

    task automatic do_reset();
        rst     = 1'b1;
        f_req   = 1'b0;
        f_addr  = '0;
        d_req   = 1'b0;
        d_addr  = '0;
        d_we    = 1'b0;
        d_sel   = 1'b0;
        d_wdata = '0;
        m_ready = 1'b1;
        m_done  = 1'b0;
        m_rdata = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({f_gnt, d_gnt, f_done, f_err, d_done, d_err} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_port_flags got %b want 000000",
                     {f_gnt, d_gnt, f_done, f_err, d_done, d_err});
        end
        n_checks++;
        if ({m_start, m_abort, m_cs_sel} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl got %b want 0000",
                     {m_start, m_abort, m_cs_sel});
        end
        n_checks++;
        if (rdata !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_rdata got %h want 0", rdata);
        end
    endtask

    task automatic test_fetch_read();
        f_addr = 24'h000100;
        f_req  = 1'b1;
        @(negedge clk);
        n_checks++;
        if (m_start !== 1'b1 || m_cs_sel !== 2'b01 || f_gnt !== 1'b1) begin
            n_fail++;
            $display("FAIL fetch_issue got start=%b cs=%b gnt=%b want 1 01 1",
                     m_start, m_cs_sel, f_gnt);
        end
        n_checks++;
        if (m_addr !== 24'h000100 || m_we !== 1'b0) begin
            n_fail++;
            $display("FAIL fetch_addr got %h we=%b want 000100 we=0",
                     m_addr, m_we);
        end
        repeat (4) @(negedge clk);
        n_checks++;
        if (m_start !== 1'b0 || m_cs_sel !== 2'b01 || f_done !== 1'b0) begin
            n_fail++;
            $display("FAIL fetch_busy got start=%b cs=%b done=%b want 0 01 0",
                     m_start, m_cs_sel, f_done);
        end
        m_done  = 1'b1;
        m_rdata = 32'hDEADBEEF;
        @(negedge clk);
        m_done = 1'b0;
        f_req  = 1'b0;
        n_checks++;
        if (f_done !== 1'b1 || rdata !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL fetch_done got done=%b rdata=%h want 1 deadbeef",
                     f_done, rdata);
        end
        n_checks++;
        if (f_gnt !== 1'b0 || m_cs_sel !== 2'b00) begin
            n_fail++;
            $display("FAIL fetch_gap1 got gnt=%b cs=%b want 0 00",
                     f_gnt, m_cs_sel);
        end
        @(negedge clk);
        n_checks++;
        if (f_done !== 1'b0 || m_cs_sel !== 2'b00 || m_start !== 1'b0) begin
            n_fail++;
            $display("FAIL fetch_gap2 got done=%b cs=%b start=%b want 0 00 0",
                     f_done, m_cs_sel, m_start);
        end
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        do_reset();
        f_addr = 24'h000040;
        d_addr = 24'h000080;
        d_sel  = 1'b1;
        d_we   = 1'b0;
        f_req  = 1'b1;
        d_req  = 1'b1;
        for (int t = 0; t < 4; t++) begin
            int  w;
            logic exp_f;
            w = 0;
            exp_f = (t % 2 == 0);
            while (m_start !== 1'b1 && w < 20) begin
                @(negedge clk);
                w++;
            end
            n_checks++;
            if (m_start !== 1'b1) begin
                n_fail++;
                $display("FAIL rr_start_%0d got no m_start want m_start", t);
            end
            n_checks++;
            if (f_gnt !== exp_f || d_gnt !== !exp_f ||
                m_cs_sel !== (exp_f ? 2'b01 : 2'b10)) begin
                n_fail++;
                $display("FAIL rr_grant_%0d got f=%b d=%b cs=%b want f=%b",
                         t, f_gnt, d_gnt, m_cs_sel, exp_f);
            end
            @(negedge clk);
            m_done  = 1'b1;
            m_rdata = 32'hA0 + t;
            @(negedge clk);
            m_done = 1'b0;
            n_checks++;
            if (f_done !== exp_f || d_done !== !exp_f ||
                rdata !== 32'hA0 + t) begin
                n_fail++;
                $display("FAIL rr_done_%0d got f=%b d=%b rd=%h want f=%b rd=%h",
                         t, f_done, d_done, rdata, exp_f, 32'hA0 + t);
            end
        end
        f_req = 1'b0;
        d_req = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_illegal_write();
        do_reset();
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_sel   = 1'b0;
        d_wdata = 32'h11111111;
        @(negedge clk);
        n_checks++;
        if (d_err !== 1'b1 || m_start !== 1'b0 || d_gnt !== 1'b0 ||
            m_cs_sel !== 2'b00) begin
            n_fail++;
            $display("FAIL illegal_err got err=%b start=%b gnt=%b cs=%b want 1 0 0 00",
                     d_err, m_start, d_gnt, m_cs_sel);
        end
        d_req  = 1'b0;
        d_we   = 1'b0;
        f_addr = 24'h000200;
        f_req  = 1'b1;
        @(negedge clk);
        n_checks++;
        if (d_err !== 1'b0 || m_start !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_pulse got err=%b start=%b want 0 0",
                     d_err, m_start);
        end
        @(negedge clk);
        n_checks++;
        if (m_start !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_gap got start=%b want 0", m_start);
        end
        @(negedge clk);
        n_checks++;
        if (m_start !== 1'b1 || f_gnt !== 1'b1 || m_addr !== 24'h000200) begin
            n_fail++;
            $display("FAIL illegal_then_fetch got start=%b gnt=%b addr=%h want 1 1 000200",
                     m_start, f_gnt, m_addr);
        end
        @(negedge clk);
        m_done  = 1'b1;
        m_rdata = 32'h5A5A5A5A;
        @(negedge clk);
        m_done = 1'b0;
        f_req  = 1'b0;
        n_checks++;
        if (f_done !== 1'b1 || d_err !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_fetch_done got done=%b derr=%b want 1 0",
                     f_done, d_err);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_timeout();
        int k;
        f_addr = 24'h000300;
        f_req  = 1'b1;
        @(negedge clk);
        n_checks++;
        if (m_start !== 1'b1) begin
            n_fail++;
            $display("FAIL to_start got %b want 1", m_start);
        end
        k = 0;
        while (m_abort !== 1'b1 && k < 1100) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (k != 1024) begin
            n_fail++;
            $display("FAIL to_latency got %0d want 1024", k);
        end
        n_checks++;
        if (f_err !== 1'b1 || f_done !== 1'b0 || f_gnt !== 1'b0) begin
            n_fail++;
            $display("FAIL to_err got err=%b done=%b gnt=%b want 1 0 0",
                     f_err, f_done, f_gnt);
        end
        f_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (m_abort !== 1'b0 || f_err !== 1'b0) begin
            n_fail++;
            $display("FAIL to_pulse got abort=%b err=%b want 0 0",
                     m_abort, f_err);
        end
        repeat (2) @(negedge clk);
        f_addr = 24'h000304;
        f_req  = 1'b1;
        @(negedge clk);
        n_checks++;
        if (m_start !== 1'b1 || m_addr !== 24'h000304) begin
            n_fail++;
            $display("FAIL to_next_start got start=%b addr=%h want 1 000304",
                     m_start, m_addr);
        end
        @(negedge clk);
        m_done  = 1'b1;
        m_rdata = 32'hCAFEF00D;
        @(negedge clk);
        m_done = 1'b0;
        f_req  = 1'b0;
        n_checks++;
        if (f_done !== 1'b1 || rdata !== 32'hCAFEF00D || f_err !== 1'b0) begin
            n_fail++;
            $display("FAIL to_next_done got done=%b rd=%h err=%b want 1 cafef00d 0",
                     f_done, rdata, f_err);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_busy();
        do_reset();
        f_addr = 24'h000400;
        f_req  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst     = 1'b1;
        m_done  = 1'b1;
        m_rdata = 32'h77777777;
        @(negedge clk);
        n_checks++;
        if ({f_gnt, d_gnt, f_done, f_err, d_done, d_err,
             m_start, m_abort, m_cs_sel} !== 10'b0 || rdata !== 32'd0) begin
            n_fail++;
            $display("FAIL rst_busy got flags=%b rd=%h want 0 0",
                     {f_gnt, d_gnt, f_done, f_err, d_done, d_err,
                      m_start, m_abort, m_cs_sel}, rdata);
        end
        rst    = 1'b0;
        m_done = 1'b0;
        d_addr = 24'h000500;
        d_sel  = 1'b1;
        d_we   = 1'b0;
        d_req  = 1'b1;
        @(negedge clk);
        n_checks++;
        if (f_gnt !== 1'b1 || d_gnt !== 1'b0 || m_cs_sel !== 2'b01) begin
            n_fail++;
            $display("FAIL rst_tie got f=%b d=%b cs=%b want 1 0 01",
                     f_gnt, d_gnt, m_cs_sel);
        end
        @(negedge clk);
        m_done = 1'b1;
        @(negedge clk);
        m_done = 1'b0;
        f_req  = 1'b0;
        d_req  = 1'b0;
        n_checks++;
        if (f_done !== 1'b1 || d_done !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_tie_done got f=%b d=%b want 1 0",
                     f_done, d_done);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        b_rst = 1'b1;
        repeat (2) @(negedge clk);
        b_rst     = 1'b0;
        b_d_addr  = 24'h000010;
        b_d_we    = 1'b1;
        b_d_sel   = 1'b1;
        b_d_wdata = 32'h12345678;
        b_d_req   = 1'b1;
        @(negedge clk);
        n_checks++;
        if (b_m_start !== 1'b1 || b_m_we !== 1'b1 ||
            b_m_wdata !== 32'h12345678 || b_m_cs_sel !== 2'b10) begin
            n_fail++;
            $display("FAIL b2b_first got start=%b we=%b wd=%h cs=%b want 1 1 12345678 10",
                     b_m_start, b_m_we, b_m_wdata, b_m_cs_sel);
        end
        b_d_wdata = 32'hFFFFFFFF;
        @(negedge clk);
        b_m_done = 1'b1;
        @(negedge clk);
        b_m_done  = 1'b0;
        b_d_wdata = 32'h12345678;
        n_checks++;
        if (b_d_done !== 1'b1 || b_m_start !== 1'b0 || b_m_cs_sel !== 2'b00) begin
            n_fail++;
            $display("FAIL b2b_done got done=%b start=%b cs=%b want 1 0 00",
                     b_d_done, b_m_start, b_m_cs_sel);
        end
        @(negedge clk);
        n_checks++;
        if (b_m_start !== 1'b1 || b_m_wdata !== 32'h12345678 ||
            b_d_gnt !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_second got start=%b wd=%h gnt=%b want 1 12345678 1",
                     b_m_start, b_m_wdata, b_d_gnt);
        end
        @(negedge clk);
        b_m_done = 1'b1;
        @(negedge clk);
        b_m_done = 1'b0;
        b_d_req  = 1'b0;
        n_checks++;
        if (b_d_done !== 1'b1 || b_d_err !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_second_done got done=%b err=%b want 1 0",
                     b_d_done, b_d_err);
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        b_rst     = 1'b1;
        b_f_req   = 1'b0;
        b_f_addr  = '0;
        b_d_req   = 1'b0;
        b_d_addr  = '0;
        b_d_we    = 1'b0;
        b_d_sel   = 1'b0;
        b_d_wdata = '0;
        b_m_ready = 1'b1;
        b_m_done  = 1'b0;
        b_m_rdata = '0;
        @(negedge clk);
        test_reset();
        test_fetch_read();
        test_round_robin();
        test_illegal_write();
        test_timeout();
        test_reset_busy();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
